pipeline_control_unit: RTL
==========================

Name: pipeline_control_unit

Overview:
- Central stall/flush sequencer for the dual-issue 5-stage pipeline.
- Combines three inputs into per-stage write-enable, flush and bubble controls:
  - load-use hazard flag from the hazard detection unit (ID stage)
  - taken-branch redirect from EX
  - multi-cycle multiply/divide (MDU) issue from EX
- Adds a board-level single-step mode driven by a debounced push-button.
- Keeps saturating stall and flush performance counters for the debug display.

Parameters:
- MDU_LATENCY, 4, total stall cycles per MDU op (including the issue cycle); legal range 1..15.
- CNT_W, 16, width of the performance counters.

Ports:
- clk  input  1  system clock, rising edge
- rst  input  1  asynchronous, active-high reset
- hazard_i  input  1  load-use hazard from the hazard detection unit
- branch_taken_i  input  1  taken branch/jump resolved in EX, either pipe
- mdu_start_i  input  1  MDU instruction present in EX this cycle
- step_mode_i  input  1  slide switch: 1 = single-step mode
- step_btn_i  input  1  debounced one-cycle pulse from btnc
- pc_write_o  output  1  PC register write enable
- if_id_write_o  output  1  IF/ID write enable
- if_id_flush_o  output  1  clear IF/ID (both slots) to NOP
- id_ex_write_o  output  1  ID/EX write enable
- id_ex_bubble_o  output  1  load NOP into ID/EX
- ex_mem_bubble_o  output  1  load NOP into EX/MEM
- pipe_en_o  output  1  global enable for EX/MEM, MEM/WB and register-file write
- state_o  output  2  current state: 0 RUN, 1 MDU_WAIT, 2 STEP_HOLD
- stall_cnt_o  output  CNT_W  cycles stalled by a hazard or the MDU
- flush_cnt_o  output  CNT_W  cycles with if_id_flush_o = 1

Behaviour:
- Outputs are Mealy: combinational from registered state plus inputs. Registered are the state, the 4-bit MDU down-counter and both perf counters.
- Default, RUN with no event: pc_write_o = if_id_write_o = id_ex_write_o = pipe_en_o = 1; all bubble and flush outputs = 0.
- On rst assertion, asynchronous: state = RUN, MDU counter = 0, both perf counters = 0. Outputs take the RUN defaults; reset during MDU_WAIT or STEP_HOLD aborts it immediately.
- RUN priority, highest first:
  1. branch_taken_i: if_id_flush_o = 1, id_ex_bubble_o = 1, pc_write_o = 1. hazard_i is ignored (wrong-path instruction). flush_cnt increments.
  2. mdu_start_i: pc_write_o = 0, if_id_write_o = 0, id_ex_write_o = 0 (holds the MDU op in EX), ex_mem_bubble_o = 1.
     - If MDU_LATENCY > 1: load counter with MDU_LATENCY-1 and go to MDU_WAIT; otherwise stay in RUN.
     - If branch_taken_i is also 1: pc_write_o = 1 and if_id_flush_o = 1 (the redirect must not be lost), id_ex_bubble_o = 0, id_ex_write_o = 0. The MDU stall still applies.
  3. hazard_i alone: pc_write_o = 0, if_id_write_o = 0, id_ex_bubble_o = 1. One cycle only; no state change.
- RUN with step_mode_i = 1 and no MDU entry: go to STEP_HOLD next cycle. RUN therefore lasts exactly one cycle per step.
- MDU_WAIT:
  - Outputs as the mdu_start_i stall: pc/if_id/id_ex writes = 0, ex_mem_bubble_o = 1.
  - hazard_i, branch_taken_i and mdu_start_i are ignored.
  - Counter decrements each cycle. When counter = 1 on a clock edge, go to RUN (step mode is evaluated there).
- STEP_HOLD:
  - pipe_en_o = 0 and all write enables = 0; no bubble or flush. The pipeline is fully frozen.
  - step_btn_i = 1: go to RUN for one cycle.
  - step_mode_i = 0: go to RUN and stay there.
  - Inputs other than step_btn_i and step_mode_i are ignored.
- stall_cnt increments in every cycle where pc_write_o = 0 because of a hazard or the MDU (not STEP_HOLD).
- Both perf counters saturate at all-ones; there is no wrap-around.
- Illegal state encoding 3 returns to RUN on the next edge.

Test Plan:
- Reset: hold rst 3 cycles, then release with all inputs 0 -> state_o = 0, pc_write_o = 1, pipe_en_o = 1, counters 0; rst asserted mid-cycle clears outputs without waiting for a clock edge.
- Load-use: hazard_i = 1 for 1 cycle -> pc_write_o = 0, if_id_write_o = 0, id_ex_bubble_o = 1 in that cycle only; stall_cnt_o = 1.
- MDU, MDU_LATENCY = 4: mdu_start_i pulse -> exactly 4 cycles with id_ex_write_o = 0 and ex_mem_bubble_o = 1, then RUN; stall_cnt_o = 4. A branch_taken_i pulse during the wait has no effect.
- Simultaneous events: branch_taken_i = 1 with hazard_i = 1 -> if_id_flush_o = 1, pc_write_o = 1, flush_cnt_o = 1, stall_cnt_o = 0. Branch + mdu_start together -> pc_write_o = 1, if_id_flush_o = 1, id_ex_write_o = 0, then 3 MDU_WAIT cycles.
- Single-step: step_mode_i = 1 -> STEP_HOLD after 1 cycle, pipe_en_o = 0; each step_btn_i pulse gives exactly one cycle of pipe_en_o = 1. Clearing step_mode_i returns to RUN permanently.
- Abort and saturation: assert rst during cycle 2 of MDU_WAIT -> state_o = 0 immediately, counters 0. With CNT_W = 4, 20 hazard cycles -> stall_cnt_o = 15.

Source files
------------

// File: rtl/pipeline_control_unit.sv
// -----------------------------------------------------------------------------
// pipeline_control_unit
//
// Central stall/flush sequencer for the dual-issue 5-stage pipeline. It merges
// the load-use hazard (ID), the taken-branch redirect (EX) and multi-cycle
// MDU issue (EX) into per-stage write-enable, flush and bubble controls. It
// also provides a push-button single-step mode and keeps saturating stall and
// flush counters for the debug display.
//
// Parameters
//   MDU_LATENCY  total stall cycles per MDU op, issue cycle included (1..15)
//   CNT_W        width of the performance counters
//
// Ports
//   clk              system clock, rising edge
//   rst              asynchronous, active-high reset
//   hazard_i         load-use hazard from the hazard detection unit
//   branch_taken_i   taken branch/jump resolved in EX (either pipe)
//   mdu_start_i      MDU instruction present in EX this cycle
//   step_mode_i      slide switch, 1 = single-step mode
//   step_btn_i       debounced one-cycle step pulse
//   pc_write_o       PC register write enable
//   if_id_write_o    IF/ID write enable
//   if_id_flush_o    clear both IF/ID slots to NOP
//   id_ex_write_o    ID/EX write enable
//   id_ex_bubble_o   load NOP into ID/EX
//   ex_mem_bubble_o  load NOP into EX/MEM
//   pipe_en_o        global enable for EX/MEM, MEM/WB and register-file write
//   state_o          0 RUN, 1 MDU_WAIT, 2 STEP_HOLD
//   stall_cnt_o      cycles stalled by a hazard or the MDU (saturating)
//   flush_cnt_o      cycles with if_id_flush_o = 1 (saturating)
//
// All control outputs are Mealy: decoded from the registered state and the
// current inputs. Only the state, the MDU down-counter and the two
// performance counters are registered.
// -----------------------------------------------------------------------------
module pipeline_control_unit #(
    parameter int MDU_LATENCY = 4,
    parameter int CNT_W       = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             hazard_i,
    input  logic             branch_taken_i,
    input  logic             mdu_start_i,
    input  logic             step_mode_i,
    input  logic             step_btn_i,
    output logic             pc_write_o,
    output logic             if_id_write_o,
    output logic             if_id_flush_o,
    output logic             id_ex_write_o,
    output logic             id_ex_bubble_o,
    output logic             ex_mem_bubble_o,
    output logic             pipe_en_o,
    output logic [1:0]       state_o,
    output logic [CNT_W-1:0] stall_cnt_o,
    output logic [CNT_W-1:0] flush_cnt_o
);

    typedef enum logic [1:0] {
        ST_RUN       = 2'd0,
        ST_MDU_WAIT  = 2'd1,
        ST_STEP_HOLD = 2'd2
    } state_e;

    // Cycles still to wait after the issue cycle; zero when the MDU is
    // single-cycle, in which case MDU_WAIT is never entered.
    localparam logic [3:0] MDU_LOAD  = 4'(MDU_LATENCY - 1);
    localparam bit         MDU_MULTI = (MDU_LATENCY > 1);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    state_e           state_q, state_d;
    logic [3:0]       mdu_cnt_q, mdu_cnt_d;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

    logic             stall_inc;

    // -------------------------------------------------------------------------
    // Next-state and Mealy output decode
    // -------------------------------------------------------------------------
    always_comb begin
        // NOTE: every signal written here gets a default first, so no path
        // through the case statement can leave one unassigned and infer a latch.
        state_d         = state_q;
        mdu_cnt_d       = mdu_cnt_q;
        pc_write_o      = 1'b1;
        if_id_write_o   = 1'b1;
        if_id_flush_o   = 1'b0;
        id_ex_write_o   = 1'b1;
        id_ex_bubble_o  = 1'b0;
        ex_mem_bubble_o = 1'b0;
        pipe_en_o       = 1'b1;

        case (state_q)
            ST_RUN: begin
                if (mdu_start_i) begin
                    // Hold the MDU op in EX and feed NOPs downstream.
                    pc_write_o      = 1'b0;
                    if_id_write_o   = 1'b0;
                    id_ex_write_o   = 1'b0;
                    ex_mem_bubble_o = 1'b1;
                    if (branch_taken_i) begin
                        // The redirect must not be lost: take the new PC and
                        // squash the wrong-path fetch. ID/EX stays held (not
                        // bubbled) because it still carries the MDU op.
                        pc_write_o    = 1'b1;
                        if_id_flush_o = 1'b1;
                    end
                    if (MDU_MULTI) begin
                        mdu_cnt_d = MDU_LOAD;
                        state_d   = ST_MDU_WAIT;
                    end
                end else if (branch_taken_i) begin
                    // Branch beats the hazard: the hazarding instruction is on
                    // the wrong path anyway.
                    if_id_flush_o  = 1'b1;
                    id_ex_bubble_o = 1'b1;
                end else if (hazard_i) begin
                    pc_write_o     = 1'b0;
                    if_id_write_o  = 1'b0;
                    id_ex_bubble_o = 1'b1;
                end

                // In step mode RUN lasts a single cycle, unless an MDU wait
                // was just started; step mode is re-evaluated when it ends.
                if (step_mode_i && (state_d == ST_RUN)) begin
                    state_d = ST_STEP_HOLD;
                end
            end

            ST_MDU_WAIT: begin
                pc_write_o      = 1'b0;
                if_id_write_o   = 1'b0;
                id_ex_write_o   = 1'b0;
                ex_mem_bubble_o = 1'b1;
                mdu_cnt_d       = mdu_cnt_q - 4'd1;
                // "<= 1" also recovers from a counter that is somehow zero.
                if (mdu_cnt_q <= 4'd1) begin
                    mdu_cnt_d = 4'd0;
                    state_d   = ST_RUN;
                end
            end

            ST_STEP_HOLD: begin
                pc_write_o    = 1'b0;
                if_id_write_o = 1'b0;
                id_ex_write_o = 1'b0;
                pipe_en_o     = 1'b0;
                if (step_btn_i || !step_mode_i) begin
                    state_d = ST_RUN;
                end
            end

            default: begin
                // Encoding 3 is unreachable; recover to RUN on the next edge.
                state_d   = ST_RUN;
                mdu_cnt_d = 4'd0;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // Performance counters
    // -------------------------------------------------------------------------
    // A frozen pipeline in STEP_HOLD is not a stall; every other cycle with
    // the PC held is caused by a hazard or the MDU.
    assign stall_inc = !pc_write_o && (state_q != ST_STEP_HOLD);

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if (stall_inc && (stall_cnt_q != CNT_MAX)) begin
            stall_cnt_d = stall_cnt_q + CNT_ONE;
        end
        if (if_id_flush_o && (flush_cnt_q != CNT_MAX)) begin
            flush_cnt_d = flush_cnt_q + CNT_ONE;
        end
    end

    // -------------------------------------------------------------------------
    // Registers
    // -------------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_RUN;
            mdu_cnt_q   <= 4'd0;
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            mdu_cnt_q   <= mdu_cnt_d;
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign state_o     = state_q;
    assign stall_cnt_o = stall_cnt_q;
    assign flush_cnt_o = flush_cnt_q;

endmodule
